// File: rtl/rvvi_frame_fifo_pkg.sv
// Shared types and widths for the RVVI frame FIFO (rvvi section of the core package).
package rvvi_frame_fifo_pkg;

   localparam int unsigned RVVI_WORD_W = 32;
   localparam int unsigned RVVI_STRB_W = 4;
   localparam int unsigned RVVI_BEAT_W = RVVI_WORD_W + RVVI_STRB_W + 1;

   // Read-side FSM encoding
   typedef logic [0:0] rvvi_rd_state_t;
   localparam rvvi_rd_state_t RD_IDLE = 1'b0;
   localparam rvvi_rd_state_t RD_SEND = 1'b1;

   // Write-side FSM encoding (used only when frames may be dropped)
   typedef logic [0:0] rvvi_wr_state_t;
   localparam rvvi_wr_state_t WR_ACCEPT  = 1'b0;
   localparam rvvi_wr_state_t WR_DISCARD = 1'b1;

   // One stored beat: data, byte strobes and end-of-frame marker
   typedef struct packed {
      logic [RVVI_WORD_W-1:0] data;
      logic [RVVI_STRB_W-1:0] strb;
      logic                   last;
   } rvvi_beat_t;

endpackage

// File: rtl/rvvi_frame_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read (distributed-RAM style).
module rvvi_frame_ram
   import rvvi_frame_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  rvvi_beat_t      wdata_i,
   input  logic [AW-1:0]   raddr_i,
   output rvvi_beat_t      rdata_o
);

   rvvi_beat_t mem [DEPTH];

   // Write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rvvi_frame_fifo.sv
// Store-and-forward frame FIFO between the RVVI packetizer and the Ethernet TX MAC.
// A frame is presented downstream only once its Wlast beat has been written.
// Optional macro RVVI_FRAME_FIFO_DROP_EN: never stall upstream; frames that overflow
// are discarded whole and counted in DropCount.
module rvvi_frame_fifo
   import rvvi_frame_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [RVVI_WORD_W-1:0] RvviAxiWdata,
   input  logic [RVVI_STRB_W-1:0] RvviAxiWstrb,
   input  logic                   RvviAxiWlast,
   input  logic                   RvviAxiWvalid,
   output logic                   RvviAxiWready,
   output logic [RVVI_WORD_W-1:0] EthTxData,
   output logic [RVVI_STRB_W-1:0] EthTxStrb,
   output logic                   EthTxLast,
   output logic                   EthTxValid,
   input  logic                   EthTxReady,
   output logic [AW:0]            Occupancy,
   output logic [AW:0]            FramesStored
`ifdef RVVI_FRAME_FIFO_DROP_EN
   ,
   output logic [15:0]            DropCount
`endif
);

   localparam logic [AW:0] ONE     = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]    frames_q, frames_d;
   rvvi_rd_state_t rd_state_q, rd_state_d;
   logic [AW:0]    occ;
   logic           full;
   logic           wr_en;
   logic           commit;
   logic           rd_fire;
   logic           frame_done;
   rvvi_beat_t     wr_beat;
   rvvi_beat_t     rd_beat;

   assign occ  = wr_ptr_q - rd_ptr_q;
   assign full = (occ == DEPTH_W);

   assign wr_beat = '{data: RvviAxiWdata, strb: RvviAxiWstrb, last: RvviAxiWlast};

`ifdef RVVI_FRAME_FIFO_DROP_EN
   rvvi_wr_state_t wr_state_q, wr_state_d;
   logic [AW:0]    wr_commit_q, wr_commit_d;
   logic [15:0]    drop_q, drop_d;

   assign RvviAxiWready = ~reset;
   assign DropCount     = drop_q;

   // Write FSM: accept beats, or rewind to the last commit and swallow an overflowing frame
   always_comb begin
      wr_state_d  = wr_state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      drop_d      = drop_q;
      wr_en       = 1'b0;
      commit      = 1'b0;
      if (RvviAxiWvalid && RvviAxiWready) begin
         unique case (wr_state_q)
            WR_ACCEPT: begin
               if (full) begin
                  // The partial frame is lost; a full beat carrying Wlast drops the frame outright
                  wr_ptr_d = wr_commit_q;
                  if (drop_q != 16'hFFFF) begin
                     drop_d = drop_q + 16'd1;
                  end
                  if (!RvviAxiWlast) begin
                     wr_state_d = WR_DISCARD;
                  end
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + ONE;
                  if (RvviAxiWlast) begin
                     commit      = 1'b1;
                     wr_commit_d = wr_ptr_q + ONE;
                  end
               end
            end
            WR_DISCARD: begin
               if (RvviAxiWlast) begin
                  wr_state_d = WR_ACCEPT;
               end
            end
            default: ;
         endcase
      end
   end

   // Drop-path state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_state_q  <= WR_ACCEPT;
         wr_commit_q <= '0;
         drop_q      <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         wr_commit_q <= wr_commit_d;
         drop_q      <= drop_d;
      end
   end
`else
   assign RvviAxiWready = ~full & ~reset;
   assign wr_en         = RvviAxiWvalid & RvviAxiWready;
   assign commit        = wr_en & RvviAxiWlast;

   // Write pointer advance on every accepted beat
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
   end

   // Full with no complete frame means a frame exceeded DEPTH words and can never drain
   frame_fits_a: assert property (@(posedge clk) disable iff (reset) !(full && frames_q == '0))
      else $error("rvvi_frame_fifo: frame longer than DEPTH words, FIFO deadlocked");
`endif

   assign rd_fire    = (rd_state_q == RD_SEND) & EthTxReady;
   assign frame_done = rd_fire & rd_beat.last;

   // Read FSM and frame count; IDLE looks at the next count so a frame starts the cycle
   // after its commit, and SEND keeps going across back-to-back frames
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      frames_d   = frames_q;
      rd_state_d = rd_state_q;
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + ONE;
      end
      if (commit && !frame_done) begin
         frames_d = frames_q + ONE;
      end else if (!commit && frame_done) begin
         frames_d = frames_q - ONE;
      end
      unique case (rd_state_q)
         RD_IDLE: begin
            if (frames_d != '0) begin
               rd_state_d = RD_SEND;
            end
         end
         RD_SEND: begin
            if (frame_done && frames_d == '0) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Pointer, frame-count and read-state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         frames_q   <= '0;
         rd_state_q <= RD_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         frames_q   <= frames_d;
         rd_state_q <= rd_state_d;
      end
   end

   rvvi_frame_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_beat),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_beat)
   );

   assign EthTxValid   = (rd_state_q == RD_SEND);
   assign EthTxData    = rd_beat.data;
   assign EthTxStrb    = rd_beat.strb;
   assign EthTxLast    = EthTxValid & rd_beat.last;
   assign Occupancy    = occ;
   assign FramesStored = frames_q;

endmodule

// File: tb/tb_rvvi_frame_fifo.sv
// Scoreboard bench for rvvi_frame_fifo (DEPTH=32). Define RVVI_FRAME_FIFO_DROP_EN to
// exercise the frame-drop build.
module tb_rvvi_frame_fifo;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
`ifdef RVVI_FRAME_FIFO_DROP_EN
   localparam bit DropEn = 1'b1;
`else
   localparam bit DropEn = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] RvviAxiWdata = '0;
   logic [3:0]  RvviAxiWstrb = '0;
   logic        RvviAxiWlast = 1'b0;
   logic        RvviAxiWvalid = 1'b0;
   logic        RvviAxiWready;
   logic [31:0] EthTxData;
   logic [3:0]  EthTxStrb;
   logic        EthTxLast;
   logic        EthTxValid;
   logic        EthTxReady = 1'b0;
   logic [AW:0] Occupancy;
   logic [AW:0] FramesStored;
`ifdef RVVI_FRAME_FIFO_DROP_EN
   logic [15:0] DropCount;
`endif

   always #5 clk = ~clk;

   rvvi_frame_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .RvviAxiWdata  (RvviAxiWdata),
      .RvviAxiWstrb  (RvviAxiWstrb),
      .RvviAxiWlast  (RvviAxiWlast),
      .RvviAxiWvalid (RvviAxiWvalid),
      .RvviAxiWready (RvviAxiWready),
      .EthTxData     (EthTxData),
      .EthTxStrb     (EthTxStrb),
      .EthTxLast     (EthTxLast),
      .EthTxValid    (EthTxValid),
      .EthTxReady    (EthTxReady),
      .Occupancy     (Occupancy),
      .FramesStored  (FramesStored)
`ifdef RVVI_FRAME_FIFO_DROP_EN
      ,
      .DropCount     (DropCount)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: words accepted, complete frames, current partial frame, committed stream
   beat_t exp_q[$];
   beat_t cur_q[$];
   int    m_occ = 0;
   int    m_frames = 0;
   int    m_drops = 0;
   bit    m_dropping = 1'b0;
   bit    stall_prev = 1'b0;
   beat_t out_prev;
   beat_t got, want, inb;
   bit    exp_valid, exp_rdy;
   int    occ0;

   // Monitor: check visible state against the model, then advance the model for the next edge
   always @(negedge clk) begin
      got = {EthTxData, EthTxStrb, EthTxLast};
      if (reset) begin
         chk("rst_wready", RvviAxiWready, 0);
         chk("rst_valid", EthTxValid, 0);
         chk("rst_last", EthTxLast, 0);
         chk("rst_occupancy", Occupancy, 0);
         exp_q.delete();
         cur_q.delete();
         m_occ = 0;
         m_frames = 0;
         m_drops = 0;
         m_dropping = 1'b0;
         stall_prev = 1'b0;
      end else begin
         exp_valid = (m_frames != 0);
         exp_rdy   = DropEn ? 1'b1 : (m_occ != DEPTH);
         occ0      = m_occ;
         chk("occupancy", Occupancy, m_occ);
         chk("frames_stored", FramesStored, m_frames);
         chk("tx_valid", EthTxValid, exp_valid);
         chk("wready", RvviAxiWready, exp_rdy);
`ifdef RVVI_FRAME_FIFO_DROP_EN
         chk("drop_count", DropCount, m_drops);
`endif
         if (stall_prev) begin
            chk("hold_valid", EthTxValid, 1);
            chk("hold_beat", got, out_prev);
         end
         stall_prev = EthTxValid & ~EthTxReady;
         out_prev   = got;
         if (exp_valid && EthTxReady) begin
            chk("tx_queue_nonempty", exp_q.size() != 0, 1);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("tx_beat", got, want);
            m_occ--;
            if (want.l) m_frames--;
         end
         if (RvviAxiWvalid && exp_rdy) begin
            inb = {RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast};
            if (m_dropping) begin
               if (inb.l) m_dropping = 1'b0;
            end else if (occ0 == DEPTH) begin
               m_occ -= cur_q.size();
               cur_q.delete();
               if (m_drops < 65535) m_drops++;
               if (!inb.l) m_dropping = 1'b1;
            end else begin
               cur_q.push_back(inb);
               m_occ++;
               if (inb.l) begin
                  while (cur_q.size() != 0) exp_q.push_back(cur_q.pop_front());
                  m_frames++;
               end
            end
         end
      end
   end

   bit rdy_rand = 1'b0;

   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         EthTxReady = 1'($urandom_range(1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      bit ok = 1'b0;
      RvviAxiWdata  = d;
      RvviAxiWstrb  = s;
      RvviAxiWlast  = l;
      RvviAxiWvalid = 1'b1;
      while (!ok && n < 3000) begin
         @(negedge clk);
         ok = RvviAxiWready;
         step();
         n++;
      end
      RvviAxiWvalid = 1'b0;
      RvviAxiWlast  = 1'b0;
      if (!ok) chk("beat_accept_timeout", ok, 1);
   endtask

   task automatic send_frame(input int len, input int gap_pct, input bit rnd, input int base);
      for (int i = 0; i < len; i++) begin
         if (int'($urandom_range(99)) < gap_pct) repeat ($urandom_range(1, 3)) step();
         send_beat(rnd ? $urandom : 32'(base + i), rnd ? 4'($urandom) : 4'hF, i == len - 1);
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || m_occ != 0) && n < limit) begin
         step();
         n++;
      end
      chk("drain_done", (exp_q.size() == 0 && m_occ == 0), 1);
   endtask

   initial begin
      repeat (3) step();
      reset = 1'b0;
      step();

      // Single frame, sink always ready
      EthTxReady = 1'b1;
      send_frame(29, 0, 1'b0, 0);
      wait_drain(200);

      // Commit of frame 1 coincides with the final read of frame 0
      EthTxReady = 1'b0;
      send_frame(4, 0, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_beat(32'(100 + i), 4'hF, 1'b0);
      EthTxReady = 1'b1;
      repeat (3) step();
      send_beat(32'd103, 4'hF, 1'b1);
      @(negedge clk);
      chk("coincident_frames", FramesStored, 1);
      chk("coincident_head", EthTxData, 100);
      step();
      wait_drain(200);

`ifndef RVVI_FRAME_FIFO_DROP_EN
      // Two long frames against a stalled sink: fill, then release
      EthTxReady = 1'b0;
      fork
         begin
            send_frame(29, 0, 1'b0, 32'h1000);
            send_frame(29, 0, 1'b0, 32'h2000);
         end
         begin
            int n = 0;
            while (Occupancy != DEPTH && n < 500) begin
               step();
               n++;
            end
            @(negedge clk);
            chk("full_wready", RvviAxiWready, 0);
            chk("full_occupancy", Occupancy, DEPTH);
            repeat (3) step();
            EthTxReady = 1'b1;
         end
      join
      wait_drain(300);
`endif

      // Random traffic with random sink backpressure
      rdy_rand = 1'b1;
      for (int f = 0; f < 1000; f++) send_frame($urandom_range(1, 24), 25, 1'b1, 0);
      rdy_rand = 1'b0;
      step();
      EthTxReady = 1'b1;
      wait_drain(2000);

      // Reset mid-frame with one frame committed
      EthTxReady = 1'b0;
      send_frame(10, 0, 1'b0, 32'h3000);
      for (int i = 0; i < 10; i++) send_beat(32'(32'h4000 + i), 4'hF, 1'b0);
      reset = 1'b1;
      #1;
      chk("reset_valid_drop", EthTxValid, 0);
      chk("reset_wready_drop", RvviAxiWready, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_occupancy", Occupancy, 0);
      chk("post_reset_frames", FramesStored, 0);
      step();
      EthTxReady = 1'b1;
      send_frame(12, 0, 1'b0, 32'h5000);
      wait_drain(200);

`ifdef RVVI_FRAME_FIFO_DROP_EN
      // Overflowing frame B is discarded; only A remains
      EthTxReady = 1'b0;
      send_frame(29, 0, 1'b0, 32'h6000);
      send_frame(29, 0, 1'b0, 32'h7000);
      @(negedge clk);
      chk("drop_one_frame", DropCount, 1);
      chk("drop_occupancy", Occupancy, 29);
      step();
      EthTxReady = 1'b1;
      wait_drain(200);
`endif

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rvvi_frame_fifo.md
Name: rvvi_frame_fifo

Overview:
- Store-and-forward frame buffer between the RVVI packetizer (upstream) and the Ethernet TX MAC (downstream).
- Accepts 32-bit AXI-write-style beats terminated by Wlast. A frame is released downstream only after its last word has been written.
- This guarantees the MAC never underruns mid-frame while the packetizer or core stalls.
- Backpressure propagates to the packetizer via RvviAxiWready.

Parameters:
- DEPTH, 256: storage depth in 32-bit words. Must be a power of 2 and ≥ 32.
- AW, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- RvviAxiWdata  in  32  frame word from packetizer
- RvviAxiWstrb  in  4  byte strobes, stored with the word
- RvviAxiWlast  in  1  last word of frame
- RvviAxiWvalid  in  1  upstream beat valid
- RvviAxiWready  out  1  FIFO can accept a beat
- EthTxData  out  32  word to MAC
- EthTxStrb  out  4  strobes to MAC
- EthTxLast  out  1  last word of frame to MAC
- EthTxValid  out  1  downstream beat valid
- EthTxReady  in  1  MAC accepts beat
- Occupancy  out  AW+1  words currently stored
- FramesStored  out  AW+1  complete frames currently stored
- DropCount  out  16  frames discarded (present only with RVVI_FRAME_FIFO_DROP_EN)

Behaviour:
- Reset (async, active-high):
  - Clears wr_ptr, rd_ptr, FramesStored, DropCount, and both FSMs.
  - Outputs during reset: RvviAxiWready=0, EthTxValid=0, EthTxLast=0, Occupancy=0.
  - Data/strb outputs are don't-care while EthTxValid=0.
  - Reset mid-frame discards all contents, partial frames included. There is no recovery of in-flight frames.
- Storage: DEPTH x 37 bits (data, strb, last). Synchronous write, asynchronous read.
- Pointers: wr_ptr and rd_ptr are AW+1 bits.
  - Occupancy = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - full = Occupancy == DEPTH; empty = Occupancy == 0.
  - Pointers wrap naturally.
- Write accept: beat accepted when RvviAxiWvalid & RvviAxiWready.
  - Without the macro: RvviAxiWready = ~full & ~reset.
  - Accepted beat writes mem[wr_ptr[AW-1:0]], then wr_ptr++.
  - Accepted beat with Wlast is a commit: FramesStored++ next cycle.
- Read FSM:
  - RD_IDLE: EthTxValid=0. Go to RD_SEND when FramesStored != 0.
  - RD_SEND: EthTxValid=1, outputs = mem[rd_ptr]. On EthTxReady, rd_ptr++.
  - On EthTxReady & EthTxLast: FramesStored--, then RD_IDLE if FramesStored (after update) == 0, else stay in RD_SEND. Back-to-back frames have no idle cycle.
- Latency: the first word of a frame is on EthTx one cycle after its Wlast beat is accepted, provided the FIFO was idle.
- Simultaneous commit and final read in the same cycle: FramesStored is unchanged (net 0).
- Full: upstream stalls. Downstream continues draining committed frames. A read frees a slot, and RvviAxiWready rises the following cycle (registered pointer).
- A frame longer than DEPTH words without the macro is illegal and deadlocks. Flag it with a simulation assertion.
- EthTxValid, once asserted, holds with stable data until EthTxReady (AXI rule).

Optional Feature:
- Macro: RVVI_FRAME_FIFO_DROP_EN.
- With the macro:
  - RvviAxiWready = ~reset, so the packetizer is never stalled.
  - A write FSM tracks the frame: WR_ACCEPT → WR_DISCARD when a valid beat arrives while full.
  - Entering discard: wr_ptr is restored to wr_commit, the pointer value captured at the last commit.
  - WR_DISCARD silently absorbs beats until a beat with Wlast, then returns to WR_ACCEPT.
  - DropCount increments once per dropped frame and saturates at 16'hFFFF.
  - A full condition coinciding with a Wlast beat drops that frame too.
- Without the macro: backpressure only, no wr_commit register, no DropCount port.

Decomposition:
- Package cvw (rvvi section):
  - RVVI_WORD_W=32
  - RVVI_STRB_W=4
  - typedef rvvi_rd_state_t {RD_IDLE, RD_SEND}
  - typedef rvvi_wr_state_t {WR_ACCEPT, WR_DISCARD}
- One sub-module: rvvi_frame_ram, a DEPTH x 37 simple dual-port RAM with sync write and async read. It is inferable as distributed RAM.

Test Plan:
- DEPTH=32. One 29-word frame (Wdata = word index), EthTxReady=1 → EthTxValid rises the cycle after the Wlast beat. 29 beats out in order with EthTxLast on beat 29. FramesStored goes 1 → 0, Occupancy ends at 0.
- DEPTH=32, EthTxReady=0, two 29-word frames sent → after 32 words, RvviAxiWready=0 and Occupancy=32. Release EthTxReady → frame 1 drains, frame 2 completes and follows with no idle cycle. Data matches.
- Frame 1's Wlast accepted in the same cycle frame 0's EthTxLast is accepted → FramesStored stays 1, and frame 1 streams next.
- Random EthTxReady (50%) and random RvviAxiWvalid gaps over 1000 frames → output stream identical to input, and EthTxData is stable whenever Valid=1 & Ready=0.
- Assert reset for 1 cycle at word 10 of a frame while 1 frame is committed → outputs drop immediately. After reset, Occupancy=0 and FramesStored=0, and the next full frame passes intact.
- With RVVI_FRAME_FIFO_DROP_EN, DEPTH=32, EthTxReady=0: frame A (29 words) committed, frame B (29 words) overflows → B discarded, DropCount=1, Occupancy=29. Only A is output after EthTxReady=1.
